trap_unit: RTL and testbench
============================

// Module: trap_unit
// PURPOSE
// - Machine-mode trap/CSR responder for the multi-cycle core; consumes the sequencer's control_op/fault_num.
// - Produces the masked ext_int/sw_int requests the sequencer samples on entry to the control stage.
// - Commits trap entry (mepc/mcause/mtval/mstatus) in the control stage and issues a PC redirect.
// - Executes mret and CSR read/write for the datapath.
// PARAMETERS
// - XLEN       32          data/address width
// - SYNC_IRQ   1           1 = 2-flop synchronise ext_irq; 0 = use ext_irq directly
// PORTS
// - clk               in   1      clock
// - reset_n           in   1      reset, synchronous, active-low
// - stage_active      in   8      one-hot stage (bit0 control ... bit7 update-pc)
// - control_op        in   2      00 trap, 01 ext_int, 10 sw_int, 11 normal
// - fault_num         in   3      exception code of the pending trap
// - pc                in   XLEN   PC of the current instruction
// - fault_addr        in   XLEN   faulting memory address
// - instr             in   XLEN   current instruction word
// - ext_irq, sw_irq   in   1      raw machine external / software interrupt lines
// - mret              in   1      current instruction decodes as mret
// - csr_op            in   2      00 none, 01 write, 10 set, 11 clear
// - csr_addr          in   12     CSR address
// - csr_wdata         in   XLEN   CSR write operand
// - csr_rdata         out  XLEN   CSR read data (combinational)
// - csr_illegal       out  1      csr_op!=0 to an unimplemented address
// - ext_int, sw_int   out  1      masked interrupt requests to the sequencer
// - redirect_valid    out  1      one-cycle pulse: load PC from redirect_pc
// - redirect_pc       out  XLEN   redirect target
// BEHAVIOUR
// - Reset values:
//   - mstatus.MIE(3) = 0, mstatus.MPIE(7) = 0; mie = 0; mtvec = 0; mepc = 0; mcause = 0; mtval = 0.
//   - Synchroniser flops = 0; redirect_valid = 0; redirect_pc = 0.
// - Stage phase:
//   - stage_q registers stage_active.
//   - "entry" = stage bit set now and clear in stage_q; each stage lasts >= 2 cycles.
//   - While reset_n = 0, entry is suppressed.
// - Interrupt outputs (combinational from registered state):
//   - ext_int = MIE & mie[11] & ext_irq_s
//   - sw_int  = MIE & mie[3]  & sw_irq
// - Trap entry: on control-stage entry with control_op != 11, in one cycle:
//   - mepc <= {pc[XLEN-1:2], 2'b00}
//   - MPIE <= MIE; MIE <= 0
//   - mcause <= 00: {0, fault_num}; 01: 0x8000000B; 10: 0x80000003
//   - mtval <= fault_addr for fault_num in {000, 001, 100, 101, 110, 111}; instr for 010; 0 otherwise
//   - Next cycle: redirect_valid = 1, redirect_pc = {mtvec[XLEN-1:2], 2'b00}
// - control_op == 11 at control entry: no CSR change, no redirect.
// - CSR access: committed on write-back-stage entry only.
//   - write: r = wdata; set: r |= wdata; clear: r &= ~wdata.
//   - Implemented: mstatus 0x300 (only bits 3, 7 writable), mie 0x304 (bits 3, 11), mtvec 0x305 (bits 1:0 forced 0),
//     mepc 0x341 (bits 1:0 forced 0), mcause 0x342, mtval 0x343, mip 0x344 (read-only {ext_irq_s<<11 | sw_irq<<3}).
//   - Write to mip: ignored, not illegal.
//   - Unimplemented address: csr_illegal = 1, no state change, csr_rdata = 0.
//   - csr_illegal is decode-only; the illegal-instruction fault is raised externally.
// - mret: on update-pc-stage entry with mret = 1:
//   - MIE <= MPIE; MPIE <= 1
//   - Next cycle: redirect_valid = 1, redirect_pc = mepc
// - Boundaries:
//   - A faulted instruction never reaches write-back/update-pc, so an aborted CSR op or mret never commits.
//   - An interrupt asserted after control entry waits for the next control stage.
//   - reset_n low mid-trap: all state returns to reset values that cycle; no redirect pulse.
//   - XLEN arithmetic: no overflow paths; all masks are applied on write.
// STRUCTURE
// - core_pkg: STAGE_* indices, NUM_STAGES, control_op/csr_op enums, CSR address constants, cause codes.
// - Sub-module irq_sync (2-flop synchroniser, reset 0), instanced when SYNC_IRQ = 1.
// - Remainder flat: CSR file + entry detection + redirect register.
// TESTING
// - Reset, then mtvec <= 0x100 (write), control entry with control_op = 00, fault_num = 010, pc = 0x44, instr = 0xFFFFFFFF
//   -> mepc = 0x44, mcause = 2, mtval = 0xFFFFFFFF, redirect_pc = 0x100 pulse 1 cycle.
// - MIE = 1, mie = 0x800, ext_irq = 1 -> ext_int = 1 after 2 cycles of sync.
//   - Control entry with op = 01 -> mcause = 0x8000000B, MIE = 0, MPIE = 1, ext_int drops.
// - Load access fault: op = 00, fault_num = 101, fault_addr = 0x2003 -> mcause = 5, mtval = 0x2003.
//   - Store misaligned: fault_num = 110 -> mcause = 6.
// - mepc = 0x80, MPIE = 1, mret at update-pc entry -> redirect_pc = 0x80, MIE = 1, MPIE = 1.
// - csr_op = 10 to 0x300 with 0xFFFFFFFF -> mstatus reads 0x88.
//   - Access to 0x7C0 -> csr_illegal = 1, rdata = 0.
//   - reset_n low during the trap cycle -> no redirect, all CSRs = 0.

Source files
------------

// File: rtl/trap_unit_pkg.sv
// trap_unit_pkg: stage indices, op encodings, CSR addresses and cause codes for the trap unit
package trap_unit_pkg;
  localparam int NUM_STAGES = 8;
  localparam int STAGE_CONTROL = 0;
  localparam int STAGE_WB = 6;
  localparam int STAGE_UPDATE_PC = 7;
  localparam int MSTATUS_MIE = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MEIE = 11;
  localparam int MIE_MSIE = 3;
  typedef enum logic [1:0] {
    OP_TRAP    = 2'b00,
    OP_EXT_INT = 2'b01,
    OP_SW_INT  = 2'b10,
    OP_NORMAL  = 2'b11
  } ctrl_op_e;
  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam logic [3:0] CAUSE_M_EXT = 4'd11;
  localparam logic [3:0] CAUSE_M_SW  = 4'd3;
endpackage

// File: rtl/trap_unit_if.sv
// trap_unit_if: sequencer/datapath bundle between the core and the trap unit
interface trap_unit_if #(parameter int XLEN = 32);
  logic [trap_unit_pkg::NUM_STAGES-1:0] stage_active;
  logic [1:0]      control_op;
  logic [2:0]      fault_num;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fault_addr;
  logic [XLEN-1:0] instr;
  logic            mret;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            ext_int;
  logic            sw_int;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  modport master (
    output stage_active, control_op, fault_num, pc, fault_addr, instr, mret, csr_op, csr_addr, csr_wdata,
    input  csr_rdata, csr_illegal, ext_int, sw_int, redirect_valid, redirect_pc
  );
  modport slave (
    input  stage_active, control_op, fault_num, pc, fault_addr, instr, mret, csr_op, csr_addr, csr_wdata,
    output csr_rdata, csr_illegal, ext_int, sw_int, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_unit_irq_sync.sv
// trap_unit_irq_sync: two-flop synchroniser for an asynchronous interrupt line
module trap_unit_irq_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], d};
  always_ff @(posedge clk) sync_q <= reset_n ? sync_d : 2'b00;
  assign q = sync_q[1];
endmodule

// File: rtl/trap_unit.sv
// trap_unit: machine-mode CSR file, trap entry, mret and PC redirect for the multi-cycle core
module trap_unit
  import trap_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit SYNC_IRQ = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ext_irq,
  input  logic        sw_irq,
  trap_unit_if.slave  bus
);
  logic [NUM_STAGES-1:0] stage_q, stage_d, entry;
  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            ext_irq_s;
  logic            csr_hit, csr_we, trap, do_mret;
  logic [XLEN-1:0] csr_rd, csr_new, mstatus_rd, mip_rd, mie_wr, int_cause, trap_cause, trap_tval;
  localparam logic [XLEN-1:0] ALIGN4 = ~XLEN'(3);
  if (SYNC_IRQ) begin : g_sync
    trap_unit_irq_sync u_sync (.clk(clk), .reset_n(reset_n), .d(ext_irq), .q(ext_irq_s));
  end else begin : g_nosync
    assign ext_irq_s = ext_irq;
  end
  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE] = mstatus_mie_q;
    mstatus_rd[MSTATUS_MPIE] = mstatus_mpie_q;
    mip_rd = '0;
    mip_rd[MIE_MEIE] = ext_irq_s;
    mip_rd[MIE_MSIE] = sw_irq;
    csr_hit = 1'b1;
    csr_rd = '0;
    case (bus.csr_addr)
      CSR_MSTATUS: csr_rd = mstatus_rd;
      CSR_MIE:     csr_rd = mie_q;
      CSR_MTVEC:   csr_rd = mtvec_q;
      CSR_MEPC:    csr_rd = mepc_q;
      CSR_MCAUSE:  csr_rd = mcause_q;
      CSR_MTVAL:   csr_rd = mtval_q;
      CSR_MIP:     csr_rd = mip_rd;
      default:     csr_hit = 1'b0;
    endcase
    csr_new = bus.csr_op == CSR_WRITE ? bus.csr_wdata :
              bus.csr_op == CSR_SET   ? csr_rd | bus.csr_wdata : csr_rd & ~bus.csr_wdata;
    mie_wr = '0;
    mie_wr[MIE_MEIE] = csr_new[MIE_MEIE];
    mie_wr[MIE_MSIE] = csr_new[MIE_MSIE];
    int_cause = '0;
    int_cause[XLEN-1] = 1'b1;
    int_cause[3:0] = bus.control_op == OP_EXT_INT ? CAUSE_M_EXT : CAUSE_M_SW;
    trap_cause = bus.control_op == OP_TRAP ? XLEN'(bus.fault_num) : int_cause;
    trap_tval = bus.fault_num == 3'b010 ? bus.instr : bus.fault_num == 3'b011 ? '0 : bus.fault_addr;
  end
  // entries are single-cycle events; gating with reset_n keeps a reset cycle from committing anything
  always_comb begin
    stage_d = bus.stage_active;
    entry = bus.stage_active & ~stage_q & {NUM_STAGES{reset_n}};
    trap = entry[STAGE_CONTROL] && bus.control_op != OP_NORMAL;
    do_mret = entry[STAGE_UPDATE_PC] && bus.mret;
    csr_we = entry[STAGE_WB] && bus.csr_op != CSR_NONE && csr_hit;
    mstatus_mie_d = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d = mie_q;
    mtvec_d = mtvec_q;
    mepc_d = mepc_q;
    mcause_d = mcause_q;
    mtval_d = mtval_q;
    redirect_valid_d = trap || do_mret;
    redirect_pc_d = trap ? mtvec_q : do_mret ? mepc_q : redirect_pc_q;
    if (csr_we) begin
      case (bus.csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_d = csr_new[MSTATUS_MIE];
          mstatus_mpie_d = csr_new[MSTATUS_MPIE];
        end
        CSR_MIE:    mie_d = mie_wr;
        CSR_MTVEC:  mtvec_d = csr_new & ALIGN4;
        CSR_MEPC:   mepc_d = csr_new & ALIGN4;
        CSR_MCAUSE: mcause_d = csr_new;
        CSR_MTVAL:  mtval_d = csr_new;
        default: ;
      endcase
    end
    if (trap) begin
      mepc_d = bus.pc & ALIGN4;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d = 1'b0;
      mcause_d = trap_cause;
      mtval_d = trap_tval;
    end
    if (do_mret) begin
      mstatus_mie_d = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_q <= '0;
      mstatus_mie_q <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q <= '0;
      mtvec_q <= '0;
      mepc_q <= '0;
      mcause_q <= '0;
      mtval_q <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      stage_q <= stage_d;
      mstatus_mie_q <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q <= mie_d;
      mtvec_q <= mtvec_d;
      mepc_q <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q <= mtval_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end
  assign bus.csr_rdata = csr_rd;
  assign bus.csr_illegal = bus.csr_op != CSR_NONE && !csr_hit;
  assign bus.ext_int = mstatus_mie_q & mie_q[MIE_MEIE] & ext_irq_s;
  assign bus.sw_int = mstatus_mie_q & mie_q[MIE_MSIE] & sw_irq;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc = redirect_pc_q;
endmodule

// File: tb/tb_trap_unit.sv
// tb_trap_unit: directed vector table plus interrupt, illegal-CSR and reset sequences for trap_unit
module tb_trap_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ext_irq = 1'b0;
  logic sw_irq = 1'b0;
  int checks = 0;
  int failures = 0;
  localparam logic [7:0] S_NONE = 8'h00, S_CTL = 8'h01, S_WB = 8'h40, S_UPC = 8'h80;
  typedef struct {
    string       name;
    logic [7:0]  stage;
    logic [1:0]  cop;
    logic [2:0]  fnum;
    logic [31:0] pc, faddr, instr;
    logic        mret;
    logic [1:0]  csr_op;
    logic [11:0] caddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic [31:0] exp_rd;
    logic        exp_redir;
    logic [31:0] exp_rpc;
  } vec_t;
  vec_t vecs[$];
  trap_unit_if #(.XLEN(32)) bus();
  trap_unit #(.XLEN(32), .SYNC_IRQ(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .ext_irq(ext_irq), .sw_irq(sw_irq), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input string name, input logic [7:0] stage, input logic [1:0] cop,
                              input logic [2:0] fnum, input logic [31:0] pc, faddr, instr,
                              input logic mret, input logic [1:0] csr_op, input logic [11:0] caddr,
                              input logic [31:0] wdata, input logic [11:0] raddr, input logic [31:0] exp_rd,
                              input logic exp_redir, input logic [31:0] exp_rpc);
    vec_t v;
    v.name = name; v.stage = stage; v.cop = cop; v.fnum = fnum; v.pc = pc; v.faddr = faddr;
    v.instr = instr; v.mret = mret; v.csr_op = csr_op; v.caddr = caddr; v.wdata = wdata;
    v.raddr = raddr; v.exp_rd = exp_rd; v.exp_redir = exp_redir; v.exp_rpc = exp_rpc;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_op = 2'b00;
    bus.csr_addr = a;
    #1;
    chk(name, bus.csr_rdata, exp);
  endtask
  // one cycle with the stage idle, then the stage entry edge; returns on the negedge after it
  task automatic enter(input vec_t v);
    @(negedge clk);
    bus.stage_active = '0;
    bus.control_op = v.cop;
    bus.fault_num = v.fnum;
    bus.pc = v.pc;
    bus.fault_addr = v.faddr;
    bus.instr = v.instr;
    bus.mret = v.mret;
    bus.csr_op = v.csr_op;
    bus.csr_addr = v.caddr;
    bus.csr_wdata = v.wdata;
    @(negedge clk);
    bus.stage_active = v.stage;
    @(negedge clk);
  endtask
  initial begin
    bus.stage_active = '0;
    bus.control_op = 2'b11;
    bus.fault_num = '0;
    bus.pc = '0;
    bus.fault_addr = '0;
    bus.instr = '0;
    bus.mret = 1'b0;
    bus.csr_op = 2'b00;
    bus.csr_addr = '0;
    bus.csr_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_redir_valid", 32'(bus.redirect_valid), 0);
    chk("rst_redir_pc", bus.redirect_pc, 0);
    chk("rst_ext_int", 32'(bus.ext_int), 0);
    rd("rst_mstatus", 12'h300, 0);
    rd("rst_mtvec", 12'h305, 0);
    rd("rst_mcause", 12'h342, 0);
    reset_n = 1'b1;
    vecs.push_back(mk("mtvec_wr", S_WB, 3, 0, 0, 0, 0, 0, 1, 12'h305, 32'h100, 12'h305, 32'h100, 0, 0));
    vecs.push_back(mk("trap_mepc", S_CTL, 0, 3'b010, 32'h44, 32'h1234, 32'hFFFFFFFF, 0, 0, 0, 0, 12'h341, 32'h44, 1, 32'h100));
    vecs.push_back(mk("trap_mcause", S_NONE, 3, 0, 0, 0, 0, 0, 0, 0, 0, 12'h342, 32'h2, 0, 0));
    vecs.push_back(mk("trap_mtval", S_NONE, 3, 0, 0, 0, 0, 0, 0, 0, 0, 12'h343, 32'hFFFFFFFF, 0, 0));
    vecs.push_back(mk("trap_mstatus", S_NONE, 3, 0, 0, 0, 0, 0, 0, 0, 0, 12'h300, 32'h0, 0, 0));
    vecs.push_back(mk("load_fault", S_CTL, 0, 3'b101, 32'h48, 32'h2003, 0, 0, 0, 0, 0, 12'h342, 32'h5, 1, 32'h100));
    vecs.push_back(mk("load_mtval", S_NONE, 3, 0, 0, 0, 0, 0, 0, 0, 0, 12'h343, 32'h2003, 0, 0));
    vecs.push_back(mk("store_mis", S_CTL, 0, 3'b110, 32'h4E, 32'h3001, 0, 0, 0, 0, 0, 12'h342, 32'h6, 1, 32'h100));
    vecs.push_back(mk("store_mepc", S_NONE, 3, 0, 0, 0, 0, 0, 0, 0, 0, 12'h341, 32'h4C, 0, 0));
    vecs.push_back(mk("store_mtval", S_NONE, 3, 0, 0, 0, 0, 0, 0, 0, 0, 12'h343, 32'h3001, 0, 0));
    vecs.push_back(mk("ctl_normal", S_CTL, 3, 3'b001, 32'h90, 32'h5000, 0, 0, 0, 0, 0, 12'h342, 32'h6, 0, 0));
    vecs.push_back(mk("fault3_mtval", S_CTL, 0, 3'b011, 32'h60, 32'h777, 32'h1, 0, 0, 0, 0, 12'h343, 32'h0, 1, 32'h100));
    vecs.push_back(mk("mepc_wr", S_WB, 3, 0, 0, 0, 0, 0, 1, 12'h341, 32'h83, 12'h341, 32'h80, 0, 0));
    vecs.push_back(mk("mstatus_set", S_WB, 3, 0, 0, 0, 0, 0, 2, 12'h300, 32'hFFFFFFFF, 12'h300, 32'h88, 0, 0));
    vecs.push_back(mk("mret1", S_UPC, 3, 0, 0, 0, 0, 1, 0, 0, 0, 12'h300, 32'h88, 1, 32'h80));
    vecs.push_back(mk("mstatus_clr", S_WB, 3, 0, 0, 0, 0, 0, 3, 12'h300, 32'h8, 12'h300, 32'h80, 0, 0));
    vecs.push_back(mk("mret2", S_UPC, 3, 0, 0, 0, 0, 1, 0, 0, 0, 12'h300, 32'h88, 1, 32'h80));
    vecs.push_back(mk("mtvec_align", S_WB, 3, 0, 0, 0, 0, 0, 1, 12'h305, 32'h107, 12'h305, 32'h104, 0, 0));
    vecs.push_back(mk("mip_wr", S_WB, 3, 0, 0, 0, 0, 0, 1, 12'h344, 32'hFFFFFFFF, 12'h344, 32'h0, 0, 0));
    vecs.push_back(mk("mie_wr", S_WB, 3, 0, 0, 0, 0, 0, 1, 12'h304, 32'hFFFFFFFF, 12'h304, 32'h808, 0, 0));
    vecs.push_back(mk("mcause_wr", S_WB, 3, 0, 0, 0, 0, 0, 1, 12'h342, 32'h12345678, 12'h342, 32'h12345678, 0, 0));
    vecs.push_back(mk("mtval_set", S_WB, 3, 0, 0, 0, 0, 0, 2, 12'h343, 32'h1, 12'h343, 32'h1, 0, 0));
    vecs.push_back(mk("mret_in_wb", S_WB, 3, 0, 0, 0, 0, 1, 0, 0, 0, 12'h300, 32'h88, 0, 0));
    vecs.push_back(mk("csr_in_ctl", S_CTL, 3, 0, 0, 0, 0, 0, 1, 12'h305, 32'h0, 12'h305, 32'h104, 0, 0));
    foreach (vecs[i]) begin
      enter(vecs[i]);
      chk({vecs[i].name, "_redir"}, 32'(bus.redirect_valid), 32'(vecs[i].exp_redir));
      if (vecs[i].exp_redir) chk({vecs[i].name, "_rpc"}, bus.redirect_pc, vecs[i].exp_rpc);
      rd({vecs[i].name, "_rd"}, vecs[i].raddr, vecs[i].exp_rd);
      @(negedge clk);
      chk({vecs[i].name, "_pulse_end"}, 32'(bus.redirect_valid), 0);
    end
    // interrupt path: MIE=1, mie=0x808
    @(negedge clk);
    bus.stage_active = '0;
    ext_irq = 1'b1;
    sw_irq = 1'b1;
    #1;
    chk("sw_int_now", 32'(bus.sw_int), 1);
    chk("ext_int_sync0", 32'(bus.ext_int), 0);
    @(negedge clk);
    chk("ext_int_sync1", 32'(bus.ext_int), 0);
    @(negedge clk);
    chk("ext_int_sync2", 32'(bus.ext_int), 1);
    rd("mip_rd", 12'h344, 32'h808);
    enter(mk("ext_trap", S_CTL, 1, 0, 32'hA0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("ext_trap_redir", 32'(bus.redirect_valid), 1);
    chk("ext_trap_rpc", bus.redirect_pc, 32'h104);
    rd("ext_trap_mcause", 12'h342, 32'h8000000B);
    rd("ext_trap_mstatus", 12'h300, 32'h80);
    rd("ext_trap_mepc", 12'h341, 32'hA0);
    chk("ext_int_drop", 32'(bus.ext_int), 0);
    chk("sw_int_drop", 32'(bus.sw_int), 0);
    enter(mk("sw_trap", S_CTL, 2, 0, 32'hB0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rd("sw_trap_mcause", 12'h342, 32'h80000003);
    rd("sw_trap_mstatus", 12'h300, 32'h0);
    ext_irq = 1'b0;
    sw_irq = 1'b0;
    // unimplemented CSR address
    @(negedge clk);
    bus.stage_active = '0;
    bus.csr_op = 2'b01;
    bus.csr_addr = 12'h7C0;
    bus.csr_wdata = 32'hFFFFFFFF;
    #1;
    chk("illegal_flag", 32'(bus.csr_illegal), 1);
    chk("illegal_rdata", bus.csr_rdata, 0);
    bus.csr_addr = 12'h344;
    #1;
    chk("mip_not_illegal", 32'(bus.csr_illegal), 0);
    bus.csr_op = 2'b00;
    bus.csr_addr = 12'h7C0;
    #1;
    chk("no_op_not_illegal", 32'(bus.csr_illegal), 0);
    enter(mk("illegal_wr", S_WB, 3, 0, 0, 0, 0, 0, 1, 12'h7C0, 32'hFFFFFFFF, 0, 0, 0, 0));
    rd("illegal_mtvec", 12'h305, 32'h104);
    rd("illegal_mcause", 12'h342, 32'h80000003);
    // reset asserted on the trap-entry edge
    @(negedge clk);
    bus.stage_active = '0;
    bus.control_op = 2'b00;
    bus.fault_num = 3'b101;
    bus.pc = 32'h200;
    bus.fault_addr = 32'h999;
    @(negedge clk);
    bus.stage_active = S_CTL;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_trap_redir", 32'(bus.redirect_valid), 0);
    chk("rst_trap_rpc", bus.redirect_pc, 0);
    bus.stage_active = '0;
    reset_n = 1'b1;
    rd("rst_trap_mstatus", 12'h300, 0);
    rd("rst_trap_mie", 12'h304, 0);
    rd("rst_trap_mtvec", 12'h305, 0);
    rd("rst_trap_mepc", 12'h341, 0);
    rd("rst_trap_mcause", 12'h342, 0);
    rd("rst_trap_mtval", 12'h343, 0);
    @(negedge clk);
    chk("rst_trap_no_pulse", 32'(bus.redirect_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
